calc_rr_scheduler: RTL and testbench
====================================

// Module: calc_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing one queue calculator among N_REQ requesters.
//  Arbitrates requests and latches the winner's operand/opcode.
//  Drives a single-cycle apply into the calculator, then returns tail/empty/valid
//  to the winner with a one-cycle ack. Sits directly in front of the calculator.
// PARAMETERS
//  N_REQ          4   number of requesters (2..8)
//  DATA_W         8   operand/result width (matches calculator in/tail)
//  SETTLE_CYCLES  1   wait cycles after apply before sampling results (1..15)
// PORTS
//  clk         in   1              clock, rising edge
//  rst         in   1              reset, asynchronous, active-high
//  req         in   N_REQ          per-requester request level
//  req_in      in   N_REQ*DATA_W   operand, slice i = requester i
//  req_op      in   N_REQ*3        calculator opcode, slice i = requester i
//  req_lock    in   N_REQ          keep grant for next op (CALC_LOCK_EN only)
//  grant       out  N_REQ          one-hot owner, ISSUE..RESP
//  ack         out  N_REQ          one-cycle completion pulse to owner
//  rsp_data    out  DATA_W         calc_tail captured at completion
//  rsp_empty   out  1              calc_empty captured at completion
//  rsp_err     out  1              !calc_valid captured at completion
//  calc_in     out  DATA_W         to calculator in
//  calc_op     out  3              to calculator op
//  calc_apply  out  1              to calculator apply, one-cycle pulse
//  calc_tail   in   DATA_W         from calculator tail
//  calc_empty  in   1              from calculator empty
//  calc_valid  in   1              from calculator valid
// BEHAVIOUR
//  - Reset: state=IDLE, grant/ack/calc_apply=0, rsp_*=0, calc_in/op=0,
//    rr pointer=N_REQ-1 (requester 0 wins first). Reset mid-op aborts: no ack.
//  - FSM IDLE->ISSUE->SETTLE->RESP->IDLE.
//  - IDLE: if |req, winner = first set bit scanning from ptr+1 cyclically;
//    latch req_in/req_op slices into calc_in/calc_op; grant<=onehot; ptr<=winner.
//  - ISSUE: calc_apply=1 exactly this cycle; -> SETTLE.
//  - SETTLE: count SETTLE_CYCLES cycles; -> RESP.
//  - RESP: ack[winner]=1 for one cycle; rsp_data<=calc_tail,
//    rsp_empty<=calc_empty, rsp_err<=~calc_valid; rsp_* valid with ack and held
//    until next RESP; grant clears; -> IDLE.
//  - Latency req->ack = 3+SETTLE_CYCLES cycles when idle; no back-to-back overlap.
//  - Requester holds req/req_in/req_op stable until ack; req still high in the
//    cycle after ack is a new request (re-arbitrated, ptr already advanced).
//  - req drop before ack is ignored: op completes, ack still pulses.
//  - Calculator error is sticky: later ops still sequenced, each returns rsp_err=1.
//  - calc_in/calc_op hold last latched values while idle; calc_apply never
//    asserted outside ISSUE.
// CONFIGURATION
//  CALC_LOCK_EN defined: if req_lock[winner]=1 in RESP, next IDLE grants the same
//    requester when its req is high, bypassing round-robin; ptr unchanged.
//  CALC_LOCK_EN undefined: req_lock ignored; pure round-robin.
// TESTING
//  1 rst high mid-SETTLE -> no ack, calc_apply=0, grant=0, next op starts from req0.
//  2 req=0001, in=8'h05, push op -> calc_apply 1 cycle at ISSUE, ack=0001 at cycle 4,
//    rsp_data=8'h05, rsp_empty=0, rsp_err=0.
//  3 req=1111 held -> grants in order 0,1,2,3,0, one ack every 4 cycles.
//  4 req=0110, req1 dropped after ack -> next grant 2, then 2 again (only one left).
//  5 calculator reports valid=0 (div by 0) -> rsp_err=1 on this and all later acks.
//  6 CALC_LOCK_EN, req=0011, req_lock=0001 -> grants 0,0,0; lock low -> grant 1.

Source files
------------

// File: rtl/calc_rr_scheduler.sv
// Round-robin scheduler sharing one queue calculator among N_REQ requesters.
// Latency: req->ack = 3+SETTLE_CYCLES cycles from idle; one op in flight at a time.
// Backpressure: requesters hold req/operands until ack; losers wait in round-robin order.
// Optional: define CALC_LOCK_EN so a winner asserting req_lock keeps the calculator.
module calc_rr_scheduler #(
  parameter int N_REQ         = 4,
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_in,
  input  logic [N_REQ*3-1:0]      req_op,
  input  logic [N_REQ-1:0]        req_lock,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_empty,
  output logic                    rsp_err,
  output logic [DATA_W-1:0]       calc_in,
  output logic [2:0]              calc_op,
  output logic                    calc_apply,
  input  logic [DATA_W-1:0]       calc_tail,
  input  logic                    calc_empty,
  input  logic                    calc_valid
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr;         // last round-robin winner
  logic [IDX_W-1:0]  owner;       // requester currently holding the calculator
  logic [3:0]        settle_cnt;
  logic              rr_hit;
  logic [IDX_W-1:0]  rr_idx;
  logic              win_hit;
  logic [IDX_W-1:0]  win_idx;
  logic              win_rr;      // winner came from round-robin, so ptr moves
  logic [N_REQ-1:0]  win_oh;
  logic [DATA_W-1:0] win_in;
  logic [2:0]        win_op;

  // Round-robin pick: first requester after ptr, wrapping around
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!rr_hit && req[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + N_REQ))) begin
          rr_hit = 1'b1;
          rr_idx = IDX_W'(i);
        end
      end
    end
  end

`ifdef CALC_LOCK_EN
  logic lock_q;
  logic lock_hit;

  assign lock_hit = lock_q && req[owner];
  assign win_hit  = lock_hit || rr_hit;
  assign win_idx  = lock_hit ? owner : rr_idx;
  assign win_rr   = !lock_hit;

  // Lock request sampled at completion; consumed by the next grant decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (state == S_RESP) begin
      lock_q <= req_lock[owner];
    end else if (state == S_IDLE && win_hit) begin
      lock_q <= 1'b0;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign win_hit     = rr_hit;
  assign win_idx     = rr_idx;
  assign win_rr      = 1'b1;
`endif

  // Steer the winner's operand/opcode and build its one-hot grant
  always_comb begin
    win_in = '0;
    win_op = '0;
    win_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_in    = req_in[i*DATA_W +: DATA_W];
        win_op    = req_op[i*3 +: 3];
        win_oh[i] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: issue, settle for SETTLE_CYCLES, respond, back to idle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (win_hit) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == 4'(SETTLE_CYCLES - 1)) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Apply pulse exists only in ISSUE
  always_comb begin
    calc_apply = (state == S_ISSUE);
  end

  // Datapath: latch winner at grant, capture results and pulse ack at completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= IDX_W'(N_REQ - 1);
      owner      <= '0;
      grant      <= '0;
      ack        <= '0;
      rsp_data   <= '0;
      rsp_empty  <= 1'b0;
      rsp_err    <= 1'b0;
      calc_in    <= '0;
      calc_op    <= '0;
      settle_cnt <= '0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          settle_cnt <= '0;
          if (win_hit) begin
            calc_in <= win_in;
            calc_op <= win_op;
            grant   <= win_oh;
            owner   <= win_idx;
            if (win_rr) ptr <= win_idx;
          end
        end
        S_SETTLE: settle_cnt <= settle_cnt + 4'd1;
        S_RESP: begin
          ack       <= grant;
          rsp_data  <= calc_tail;
          rsp_empty <= calc_empty;
          rsp_err   <= ~calc_valid;
          grant     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_rr_scheduler.sv
// Directed bench for calc_rr_scheduler with a small behavioural queue calculator.
// Latency: checks req->ack of 4 cycles with SETTLE_CYCLES=1.
// Backpressure: requesters hold request until ack, as the scheduler expects.
module tb_calc_rr_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_CLR  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_in = '0;
  logic [N*3-1:0] req_op = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N-1:0]   grant, ack;
  logic [W-1:0]   rsp_data;
  logic           rsp_empty, rsp_err;
  logic [W-1:0]   calc_in;
  logic [2:0]     calc_op;
  logic           calc_apply;
  logic [W-1:0]   calc_tail;
  logic           calc_empty;
  logic           calc_valid;

  int checks = 0;
  int errors = 0;

  calc_rr_scheduler #(.N_REQ(N), .DATA_W(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_in(req_in), .req_op(req_op),
    .req_lock(req_lock), .grant(grant), .ack(ack), .rsp_data(rsp_data),
    .rsp_empty(rsp_empty), .rsp_err(rsp_err), .calc_in(calc_in),
    .calc_op(calc_op), .calc_apply(calc_apply), .calc_tail(calc_tail),
    .calc_empty(calc_empty), .calc_valid(calc_valid)
  );

  always #5 clk = ~clk;

  // Behavioural calculator: push/clear/divide, error sticky until reset
  logic err_q;
  assign calc_valid = ~err_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      calc_tail  <= '0;
      calc_empty <= 1'b1;
      err_q      <= 1'b0;
    end else if (calc_apply) begin
      case (calc_op)
        OP_PUSH: begin calc_tail <= calc_in; calc_empty <= 1'b0; end
        OP_CLR:  begin calc_tail <= '0; calc_empty <= 1'b1; end
        OP_DIV:  if (calc_in == '0) err_q <= 1'b1;
                 else calc_tail <= calc_tail / calc_in;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] dat;       // requester i operand = dat + i
    logic [2:0]   op;
    logic [N-1:0] lock;
    logic [N-1:0] exp_ack;
    logic [W-1:0] exp_in;
    logic [W-1:0] exp_data;
    logic         exp_empty;
    logic         exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    req      = v.req;
    req_lock = v.lock;
    for (int i = 0; i < N; i++) begin
      req_in[i*W +: W] = v.dat + W'(i);
      req_op[i*3 +: 3] = v.op;
    end
  endtask

  // Called at a negedge while the scheduler is idle (or in an ack cycle)
  task automatic run_op(input vec_t v, input string nm);
    int lat = 0;
    int napply = 0;
    logic [N-1:0] g_at = '0;
    logic [W-1:0] in_at = '0;
    logic [2:0]   op_at = '0;
    drive(v);
    do begin
      @(negedge clk);
      lat++;
      if (calc_apply) begin
        napply++;
        g_at  = grant;
        in_at = calc_in;
        op_at = calc_op;
      end
    end while (ack == '0 && lat < 20);
    chk({nm, " latency"}, lat, 4);
    chk({nm, " ack"}, ack, v.exp_ack);
    chk({nm, " apply count"}, napply, 1);
    chk({nm, " grant at apply"}, g_at, v.exp_ack);
    chk({nm, " calc_in"}, in_at, v.exp_in);
    chk({nm, " calc_op"}, op_at, v.op);
    chk({nm, " rsp_data"}, rsp_data, v.exp_data);
    chk({nm, " rsp_empty"}, rsp_empty, v.exp_empty);
    chk({nm, " rsp_err"}, rsp_err, v.exp_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    req_lock = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[11];
  vec_t v;
  logic [N-1:0] lk_exp[4];
  logic [N-1:0] lk_lock[4];
  int acks_seen;
  int wait_cnt;

  initial begin
    // req, dat, op, lock, exp_ack, exp_in, exp_data, exp_empty, exp_err
    tbl[0]  = '{4'b0001, 8'h05, OP_PUSH, 4'b0000, 4'b0001, 8'h05, 8'h05, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 8'h20, OP_PUSH, 4'b0000, 4'b0010, 8'h21, 8'h21, 1'b0, 1'b0};
    tbl[2]  = '{4'b1111, 8'h20, OP_PUSH, 4'b0000, 4'b0100, 8'h22, 8'h22, 1'b0, 1'b0};
    tbl[3]  = '{4'b1111, 8'h20, OP_PUSH, 4'b0000, 4'b1000, 8'h23, 8'h23, 1'b0, 1'b0};
    tbl[4]  = '{4'b1111, 8'h20, OP_PUSH, 4'b0000, 4'b0001, 8'h20, 8'h20, 1'b0, 1'b0};
    tbl[5]  = '{4'b0110, 8'h30, OP_PUSH, 4'b0000, 4'b0010, 8'h31, 8'h31, 1'b0, 1'b0};
    tbl[6]  = '{4'b0100, 8'h30, OP_PUSH, 4'b0000, 4'b0100, 8'h32, 8'h32, 1'b0, 1'b0};
    tbl[7]  = '{4'b0100, 8'h30, OP_PUSH, 4'b0000, 4'b0100, 8'h32, 8'h32, 1'b0, 1'b0};
    tbl[8]  = '{4'b1000, 8'h00, OP_CLR,  4'b0000, 4'b1000, 8'h03, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{4'b0001, 8'h00, OP_DIV,  4'b0000, 4'b0001, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[10] = '{4'b0010, 8'h40, OP_PUSH, 4'b0000, 4'b0010, 8'h41, 8'h41, 1'b0, 1'b1};

`ifdef CALC_LOCK_EN
    lk_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
    lk_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
    lk_lock = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset grant", grant, 0);
    chk("reset ack", ack, 0);
    chk("reset calc_apply", calc_apply, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset rsp_empty", rsp_empty, 0);
    chk("reset rsp_err", rsp_err, 0);
    chk("reset calc_in", calc_in, 0);
    chk("reset calc_op", calc_op, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table: single op, full round-robin, drop-out, clear, div-by-zero, sticky error
    for (int t = 0; t < 11; t++) begin
      run_op(tbl[t], $sformatf("vec%0d", t));
    end

    // Reset in the middle of SETTLE aborts the op
    v = '{4'b0100, 8'h70, OP_PUSH, 4'b0000, 4'b0100, 8'h72, 8'h72, 1'b0, 1'b0};
    drive(v);
    repeat (2) @(negedge clk);
    chk("settle before reset grant", grant, 4'b0100);
    rst = 1'b1;
    #1;
    chk("midop reset grant", grant, 0);
    chk("midop reset calc_apply", calc_apply, 0);
    chk("midop reset ack", ack, 0);
    acks_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack != '0 || calc_apply) acks_seen++;
    end
    chk("midop reset quiet", acks_seen, 0);
    rst = 1'b0;
    v = '{4'b0101, 8'h80, OP_PUSH, 4'b0000, 4'b0001, 8'h80, 8'h80, 1'b0, 1'b0};
    run_op(v, "after reset req0 first");

    // Request dropped one cycle after being seen still completes
    v = '{4'b1000, 8'h60, OP_PUSH, 4'b0000, 4'b1000, 8'h63, 8'h63, 1'b0, 1'b0};
    drive(v);
    @(negedge clk);
    req = '0;
    wait_cnt = 1;
    while (ack == '0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("drop latency", wait_cnt, 4);
    chk("drop ack", ack, 4'b1000);
    chk("drop rsp_data", rsp_data, 8'h63);
    @(negedge clk);
    chk("ack one cycle", ack, 0);

    // Lock sequence from a fresh reset
    do_reset();
    for (int t = 0; t < 4; t++) begin
      v = '{4'b0011, 8'h50, OP_PUSH, lk_lock[t], lk_exp[t],
            (lk_exp[t] == 4'b0001) ? 8'h50 : 8'h51,
            (lk_exp[t] == 4'b0001) ? 8'h50 : 8'h51, 1'b0, 1'b0};
      run_op(v, $sformatf("lock%0d", t));
    end

    // Idle: operands and response held, no apply
    req = '0;
    req_lock = '0;
    acks_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (calc_apply || ack != '0 || grant != '0) acks_seen++;
    end
    chk("idle quiet", acks_seen, 0);
    chk("idle calc_in held", calc_in, 8'h51);
    chk("idle calc_op held", calc_op, OP_PUSH);
    chk("idle rsp_data held", rsp_data, 8'h51);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
